// File: rtl/sum_uart_tx.sv
`timescale 1ns/1ps
// Byte-wide UART transmitter (8N1) fed by a 4-entry FIFO.
// Queued bytes go out back to back, with no idle gap between frames.
module sum_uart_tx #(
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_level
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] TIMER_LOAD = 16'(DIV - 1);
  localparam logic [2:0]  FULL_LEVEL = 3'(DEPTH);

  state_t      state, state_next;
  logic [15:0] timer, timer_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shreg;
  logic [7:0]  mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        ready_en;
  logic        push, pop, tx_next;

  // ready_en keeps in_ready low while in reset and for the release edge itself
  assign in_ready   = ready_en && (count != FULL_LEVEL);
  assign push       = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign fifo_level = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // tx_next is decoded from the current state, so the line lags the FSM by one cycle
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_idx_next = bit_idx;
    pop          = 1'b0;
    tx_next      = 1'b1;
    case (state)
      IDLE: begin
        if (count != 3'd0) begin
          pop        = 1'b1;
          state_next = START;
          timer_next = TIMER_LOAD;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (timer == 16'd0) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          timer_next   = TIMER_LOAD;
        end else begin
          timer_next = timer - 16'd1;
        end
      end
      DATA: begin
        tx_next = shreg[bit_idx];
        if (timer == 16'd0) begin
          timer_next = TIMER_LOAD;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          timer_next = timer - 16'd1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (timer == 16'd0) begin
          if (count != 3'd0) begin
            pop        = 1'b1;
            state_next = START;
            timer_next = TIMER_LOAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
      if (pop) shreg <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
`timescale 1ns/1ps
// Scoreboard bench for sum_uart_tx: stimulus queues expected bytes,
// a monitor decodes tx frames and checks them against that queue.
module tb_sum_uart_tx;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  logic [7:0] m_in_data;
  logic       m_in_valid;
  logic       m_in_ready;
  logic       m_tx;
  logic       m_busy;
  logic [2:0] m_level;

  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  int         frames_seen = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  sum_uart_tx #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  sum_uart_tx #(.DIV(2)) dut_min (
    .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .tx(m_tx), .busy(m_busy), .fifo_level(m_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic apply_stimulus(input logic [7:0] b, output int acc);
    int t;
    t = 0;
    acc = -1;
    in_data = b;
    in_valid = 1'b1;
    while (acc < 0 && t < 200) begin
      if (in_ready) begin
        acc = cyc + 1;
        exp_q.push_back(b);
      end
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    if (acc < 0) check_output("accept_timeout", 32'(t), 32'd0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic int last_start(input int k);
    if (start_q.size() > k) return start_q[start_q.size() - 1 - k];
    return -1000;
  endfunction

  // Frame decoder: every bit level must hold for DIV samples.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        logic [9:0] bits;
        bit         aborted;
        bit         steady;
        int         st;
        st = cyc;
        aborted = 1'b0;
        steady = 1'b1;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < DIV; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            else if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) steady = 1'b0;
          end
        end
        if (!aborted) begin
          start_q.push_back(st);
          frames_seen++;
          check_output("frame_shape", {29'd0, steady, bits[0], bits[9]}, 32'b101);
          if (exp_q.size() == 0) check_output("frame_unexpected", 32'(exp_q.size()), 32'd1);
          else check_output("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin : stimulus
    int         a, a2, bc, f0, lowcnt, fb_base;
    int         acc[6];
    logic [7:0] sb[6];
    logic [7:0] r;
    logic [29:0] cap, expv;
    logic [9:0] fb;

    rst_n = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    m_in_valid = 1'b0;
    m_in_data = '0;
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_tx", {31'd0, tx}, 32'd1);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("reset_level", {29'd0, fifo_level}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("ready_after_release", {31'd0, in_ready}, 32'd1);

    // single frame 0xA5: latency and busy width
    apply_stimulus(8'hA5, a);
    in_valid = 1'b0;
    bc = 0;
    repeat (60) begin
      if (busy) bc++;
      @(negedge clk);
    end
    check_output("busy_cycles", 32'(bc), 32'd40);
    wait_drain();
    check_output("start_latency", 32'(last_start(0)), 32'(a + 2));

    // back-to-back 0x00, 0xFF
    apply_stimulus(8'h00, a);
    apply_stimulus(8'hFF, a2);
    in_valid = 1'b0;
    wait_drain();
    check_output("b2b_first_start", 32'(last_start(1)), 32'(a + 2));
    check_output("b2b_gap", 32'(last_start(0) - last_start(1)), 32'd40);

    // in_valid held high with 6 distinct bytes
    r = 8'($urandom);
    for (int i = 0; i < 6; i++) sb[i] = 8'(r + 8'(i * 29));
    for (int i = 0; i < 5; i++) apply_stimulus(sb[i], acc[i]);
    check_output("stream_first_five", 32'(acc[4] - acc[0]), 32'd4);
    check_output("stream_full_level", {29'd0, fifo_level}, 32'd4);
    check_output("stream_full_ready", {31'd0, in_ready}, 32'd0);
    apply_stimulus(sb[5], acc[5]);
    in_valid = 1'b0;
    check_output("stream_sixth_accept", 32'(acc[5] - acc[0]), 32'd42);
    wait_drain();

    // push and pop on the same edge with two bytes queued
    apply_stimulus(8'($urandom), a);
    apply_stimulus(8'($urandom), a2);
    apply_stimulus(8'($urandom), a2);
    in_valid = 1'b0;
    bc = 0;
    while (cyc < a + 40 && bc < 100) begin
      @(negedge clk);
      bc++;
    end
    check_output("same_edge_level_before", {29'd0, fifo_level}, 32'd2);
    apply_stimulus(8'($urandom), a2);
    in_valid = 1'b0;
    check_output("same_edge_accept", 32'(a2), 32'(a + 41));
    check_output("same_edge_level_after", {29'd0, fifo_level}, 32'd2);
    wait_drain();

    // reset mid-DATA of 0x3C with two bytes queued
    apply_stimulus(8'h3C, a);
    apply_stimulus(8'($urandom), a2);
    apply_stimulus(8'($urandom), a2);
    in_valid = 1'b0;
    bc = 0;
    while (cyc < a + 7 && bc < 100) begin
      @(negedge clk);
      bc++;
    end
    check_output("tx_before_reset", {31'd0, tx}, 32'd0);
    f0 = frames_seen;
    #1 rst_n = 1'b0;
    #1;
    check_output("midframe_reset_tx", {31'd0, tx}, 32'd1);
    check_output("midframe_reset_level", {29'd0, fifo_level}, 32'd0);
    check_output("midframe_reset_busy", {31'd0, busy}, 32'd0);
    check_output("midframe_reset_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    in_data = 8'h99;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_output("ready_after_midreset", {31'd0, in_ready}, 32'd1);
    lowcnt = 0;
    repeat (100) begin
      if (tx == 1'b0) lowcnt++;
      @(negedge clk);
    end
    check_output("idle_after_reset_tx", 32'(lowcnt), 32'd0);
    check_output("no_frames_after_reset", 32'(frames_seen), 32'(f0));

    // randomized bytes with random gaps
    f0 = frames_seen;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(8'($urandom), a);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    wait_drain();
    check_output("random_frame_count", 32'(frames_seen - f0), 32'd16);

    // minimum divider instance, 0x81
    m_in_data = 8'h81;
    m_in_valid = 1'b1;
    check_output("min_ready", {31'd0, m_in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    m_in_valid = 1'b0;
    fb = {1'b1, 8'h81, 1'b0};
    fb_base = 2;
    cap = '0;
    expv = '1;
    bc = 0;
    for (int k = 0; k < 30; k++) begin
      cap[k] = m_tx;
      if (k >= fb_base && k < fb_base + 20) expv[k] = fb[(k - fb_base) / 2];
      if (m_busy) bc++;
      @(negedge clk);
    end
    check_output("min_div_waveform", {2'd0, cap}, {2'd0, expv});
    check_output("min_div_busy", 32'(bc), 32'd20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
SUM_UART_TX -- requirements
Module: sum_uart_tx

Interface
REQ-001: Parameter DIV, default 4, meaning clock cycles per UART bit; legal range 2..65535.
REQ-002: Parameter DEPTH, fixed at 4, meaning the number of byte entries in the input FIFO.
REQ-003: clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  meaning the asynchronous, active-low reset; asserting it forces reset state immediately, and release is synchronous to clk.
REQ-005: in_data  input  8  meaning the byte to transmit, typically the upstream sum result.
REQ-006: in_valid  input  1  meaning in_data is valid this cycle.
REQ-007: in_ready  output  1  meaning the block can accept a byte this cycle.
REQ-008: tx  output  1  meaning the UART serial line, 8N1, idle high, driven from a register.
REQ-009: busy  output  1  meaning the FSM is not in IDLE.
REQ-010: fifo_level  output  3  meaning the number of bytes held in the FIFO, 0..4.

Function
REQ-011: A byte SHALL be accepted on a rising edge when in_valid=1 and in_ready=1, and not otherwise.
REQ-012: in_ready SHALL equal (fifo_level != 4), decoded from the registered count only, so a full FIFO refuses a push even when a pop happens in the same cycle.
REQ-013: The FIFO SHALL be first-in first-out. When a push and a pop occur on the same edge, fifo_level SHALL stay unchanged and data order SHALL be preserved.
REQ-014: The FSM SHALL have the states IDLE, START, DATA and STOP, with a bit timer counting from DIV-1 down to 0 and a 3-bit bit index.
REQ-015: In IDLE with fifo_level>0, on the next edge the FSM SHALL pop the FIFO head into the shift register, load the timer with DIV-1, and enter START.
REQ-016: In START, tx SHALL be 0 for exactly DIV cycles; when the timer reaches 0 the FSM SHALL enter DATA with bit index 0.
REQ-017: In DATA, tx SHALL present shift-register bits LSB first, each for exactly DIV cycles; after bit 7 the FSM SHALL enter STOP.
REQ-018: In STOP, tx SHALL be 1 for exactly DIV cycles. On the final STOP cycle:
  - if fifo_level>0, the FSM SHALL pop and enter START directly, with no idle gap;
  - otherwise, it SHALL enter IDLE.
REQ-019: tx SHALL be registered and SHALL be 1 in IDLE.
REQ-020: Latency: with the FSM in IDLE and the FIFO empty, a byte accepted on edge N SHALL drive tx low from edge N+2.
REQ-021: A frame SHALL occupy exactly 10*DIV cycles, and consecutive queued frames SHALL be exactly 10*DIV cycles apart.
REQ-022: The shift register SHALL hold its value for the whole frame; in_data changes after acceptance SHALL have no effect on the frame in progress.

Reset
REQ-023: While rst_n=0, the following SHALL hold:
  - tx=1, busy=0, in_ready=0, fifo_level=0;
  - the FSM SHALL be in IDLE;
  - the timer, bit index and FIFO pointers SHALL be cleared.
REQ-024: Reset asserted mid-frame SHALL discard the frame and all queued bytes, with tx going high asynchronously.
REQ-025: After reset release, in_ready SHALL rise on the first clk edge, and no byte present during reset SHALL ever be transmitted.

Verification
REQ-026: DIV=4, push 0xA5 when idle -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; tx falls 2 edges after acceptance; busy is high for exactly 40 cycles.
REQ-027: DIV=4, push 0x00 then 0xFF back-to-back -> 80 contiguous cycles of frames; tx high during the first STOP and immediately low for the second START, with no idle cycle between frames.
REQ-028: DIV=4, in_valid held high with 6 distinct bytes while idle -> 5 accepted (1 popped, 4 queued); in_ready=0 with fifo_level=4 until the first frame's final STOP edge; the 6th is accepted the edge after; all 6 are transmitted in order.
REQ-029: Mid-DATA of byte 0x3C with 2 bytes queued, pulse rst_n low for 3 cycles -> tx=1 immediately and fifo_level=0; no further frames after release; tx stays high.
REQ-030: DIV=2, push 0x81 -> 20-cycle frame; the 2-cycle bit timing is correct at the minimum divider.
REQ-031: Push and pop on the same edge with fifo_level=2 -> fifo_level stays 2, and the transmitted byte order matches push order.
